// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-back data cache.
//   state_t     : controller FSM states
//   LINE_W      : cache line width in bits (8 words of 32 bits)
//   WORD_OFF_W  : word-within-line offset width
//   BYTE_OFF_W  : byte-within-word offset width (ignored by the cache)
//   word_off()  : extract the word offset from a byte address
//   line_word() : read one 32-bit word out of a line
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    REFILL    = 2'd3
  } state_t;

  localparam int LINE_W     = 256;
  localparam int WORD_W     = 32;
  localparam int WORD_OFF_W = 3;
  localparam int BYTE_OFF_W = 2;
  localparam int LINE_OFF_W = WORD_OFF_W + BYTE_OFF_W;

  function automatic logic [WORD_OFF_W-1:0] word_off(input logic [31:0] addr);
    return addr[BYTE_OFF_W +: WORD_OFF_W];
  endfunction

  // Bit position of a word is {off, 5'b0}, i.e. off * 32.
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [WORD_OFF_W-1:0] off);
    return line[{off, 5'b0} +: WORD_W];
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag, valid, dirty and line-data storage for the data cache.
// Every access uses the single index of the current request.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (clears valid and dirty only)
//   idx             : line index
//   rd_tag/rd_valid/rd_dirty/rd_line : asynchronous read of line idx
//   line_we, line_tag, line_data     : fill whole line, set valid, clear dirty
//   word_we, word_sel, word_data     : write one word, set dirty
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int LINES = 32,
  parameter int TAG_W = 22,
  parameter int IDX_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_W-1:0]      idx,
  output logic [TAG_W-1:0]      rd_tag,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [LINE_W-1:0]     rd_line,
  input  logic                  line_we,
  input  logic [TAG_W-1:0]      line_tag,
  input  logic [LINE_W-1:0]     line_data,
  input  logic                  word_we,
  input  logic [WORD_OFF_W-1:0] word_sel,
  input  logic [WORD_W-1:0]     word_data
);

  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINE_W-1:0] data_mem [LINES];
  logic [LINES-1:0]  valid;
  logic [LINES-1:0]  dirty;

  assign rd_tag   = tag_mem[idx];
  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];
  assign rd_line  = data_mem[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (line_we) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (word_we) begin
      dirty[idx] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless while valid is clear, so no reset.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[idx]  <= line_tag;
      data_mem[idx] <= line_data;
    end else if (word_we) begin
      data_mem[idx][{word_sel, 5'b0} +: WORD_W] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the MEM stage.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   cpu_read_i/write_i  : load / store request from EX/MEM
//   cpu_addr_i          : byte address ([4:2] word, [1:0] ignored)
//   cpu_wdata_i         : store data
//   cpu_rdata_o         : load data, valid when read && !cpu_stall_o
//   cpu_stall_o         : combinational pipeline freeze
//   mem_*               : line memory request (enable/ack)
//   state_o             : current FSM state, for observation
// Memory handshake: mem_enable_o is a level request; mem_write_o, mem_addr_o and
// mem_wdata_o are stable while it is high. The memory completes the request with a
// single-cycle mem_ack_i pulse (carrying mem_rdata_i for a fetch). An ack seen while
// no request is outstanding is ignored. The CPU side is a hold-until-not-stalled
// handshake: a request is accepted in the cycle it is present with cpu_stall_o low.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES = 32,
  // Must equal 32 - 5 - log2(LINES).
  parameter int TAG_W = 22
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_read_i,
  input  logic              cpu_write_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output state_t            state_o
);

  localparam int IDX_W = $clog2(LINES);

  state_t state_q, state_d;

  logic                  req;
  logic                  hit;
  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      req_tag;
  logic [WORD_OFF_W-1:0] off;
  logic                  addr_unused;

  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid;
  logic              rd_dirty;
  logic [LINE_W-1:0] rd_line;
  logic              line_we;
  logic              word_we;

  assign req         = cpu_read_i | cpu_write_i;
  assign idx         = cpu_addr_i[LINE_OFF_W +: IDX_W];
  assign req_tag     = cpu_addr_i[31 -: TAG_W];
  assign off         = word_off(cpu_addr_i);
  assign addr_unused = ^cpu_addr_i[BYTE_OFF_W-1:0];

  assign hit = rd_valid && (rd_tag == req_tag);

  dcache_sram #(
    .LINES (LINES),
    .TAG_W (TAG_W),
    .IDX_W (IDX_W)
  ) u_sram (
    .clk       (clk_i),
    .rst       (rst_i),
    .idx       (idx),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_line   (rd_line),
    .line_we   (line_we),
    .line_tag  (req_tag),
    .line_data (mem_rdata_i),
    .word_we   (word_we),
    .word_sel  (off),
    .word_data (cpu_wdata_i)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    line_we      = 1'b0;
    word_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          state_d = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
        end
        // A store that hits updates the line; with read+write both high the
        // write still happens and the read port shows the pre-write word.
        word_we = req && hit && cpu_write_i;
      end
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {rd_tag, idx, {LINE_OFF_W{1'b0}}};
        mem_wdata_o  = rd_line;
        if (mem_ack_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, idx, {LINE_OFF_W{1'b0}}};
        if (mem_ack_i) begin
          line_we = 1'b1;
          state_d = REFILL;
        end
      end
      REFILL: begin
        // Give the freshly written line one cycle before it is looked up as a hit.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_stall_o = req && !(state_q == IDLE && hit);
  assign cpu_rdata_o = (state_q == IDLE && hit && cpu_read_i) ? line_word(rd_line, off) : '0;
  assign state_o     = state_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;
  import dcache_pkg::*;

  localparam int LINES = 32;
  localparam int REC_W = 4 + 32 + 32 + 256;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_read, cpu_write;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic         cpu_stall;
  logic         mem_enable, mem_write, mem_ack;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata, mem_rdata;
  state_t       dbg_state;

  always #5 clk = ~clk;

  dcache_ctrl #(.LINES(32), .TAG_W(22)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cpu_read_i   (cpu_read),
    .cpu_write_i  (cpu_write),
    .cpu_addr_i   (cpu_addr),
    .cpu_wdata_i  (cpu_wdata),
    .cpu_rdata_o  (cpu_rdata),
    .cpu_stall_o  (cpu_stall),
    .mem_enable_o (mem_enable),
    .mem_write_o  (mem_write),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .mem_ack_i    (mem_ack),
    .state_o      (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [REC_W-1:0] exp_q[$];
  int   resp_lat = 1;
  logic spur     = 1'b0;

  // Reference model: cache contents and backing memory as plain arrays.
  bit           m_valid [LINES];
  bit           m_dirty [LINES];
  logic [21:0]  m_tag   [LINES];
  logic [255:0] m_data  [LINES];
  logic [255:0] m_mem   [int];
  logic [255:0] e_mem   [int];

  function automatic logic [255:0] pat_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = (la << 8) ^ 32'(w) ^ 32'h5A00_0000;
    return l;
  endfunction

  function automatic logic [255:0] m_get(input logic [31:0] la);
    if (m_mem.exists(int'(la >> 5))) return m_mem[int'(la >> 5)];
    return pat_line(la);
  endfunction

  function automatic logic [255:0] e_get(input logic [31:0] la);
    if (e_mem.exists(int'(la >> 5))) return e_mem[int'(la >> 5)];
    return pat_line(la);
  endfunction

  function automatic logic [REC_W-1:0] mk_rec(input bit stall, input bit en, input bit wr,
                                              input bit chk_rd, input logic [31:0] addr,
                                              input logic [31:0] rdata, input logic [255:0] wdata);
    return {stall, en, wr, chk_rd, addr, rdata, wdata};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- memory responder ----------------
  // Ack arrives in the resp_lat-th consecutive cycle of mem_enable high.
  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_enable === 1'b1) begin
        cnt++;
        if (cnt >= resp_lat) begin
          mem_ack = 1'b1;
          if (mem_write) e_mem[int'(mem_addr >> 5)] = mem_wdata;
          else mem_rdata = e_get(mem_addr);
          cnt = 0;
        end else begin
          mem_ack = 1'b0;
        end
      end else begin
        cnt = 0;
        mem_ack = spur;
        mem_rdata = {8{32'hBAD0_BAD0}};
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin
    logic [REC_W-1:0] r;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        chk("stall", cpu_stall, r[323]);
        chk("mem_enable", mem_enable, r[322]);
        if (r[322]) begin
          chk("mem_write", mem_write, r[321]);
          chk("mem_addr", mem_addr, r[319:288]);
          if (r[321]) chk("mem_wdata", mem_wdata, r[255:0]);
        end
        if (r[320]) chk("rdata", cpu_rdata, r[287:256]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n, input bit sp);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0; spur = sp;
      exp_q.push_back(mk_rec(0, 0, 0, 0, '0, '0, '0));
    end
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; spur = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < LINES; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
  endtask

  // One CPU access, held until the model says it completes. Model outputs are
  // returned so directed tests can pin them to hand-computed values.
  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int lat,
                        output int n_cyc, output bit did_miss, output bit did_wb,
                        output logic [31:0] wb_addr, output logic [255:0] wb_data,
                        output logic [31:0] fetch_addr);
    logic [REC_W-1:0] recs[$];
    int idx, off;
    logic [21:0] tg;
    logic [31:0] word;
    idx = int'(addr[9:5]); off = int'(addr[4:2]); tg = addr[31:10];
    did_miss = !(m_valid[idx] && m_tag[idx] == tg);
    did_wb = 0; wb_addr = '0; wb_data = '0; fetch_addr = '0;
    resp_lat = lat;
    if (did_miss) begin
      recs.push_back(mk_rec(1, 0, 0, 0, '0, '0, '0));
      if (m_valid[idx] && m_dirty[idx]) begin
        did_wb = 1;
        wb_addr = {m_tag[idx], 5'(idx), 5'b0};
        wb_data = m_data[idx];
        repeat (lat) recs.push_back(mk_rec(1, 1, 1, 0, wb_addr, '0, wb_data));
        m_mem[int'(wb_addr >> 5)] = wb_data;
      end
      fetch_addr = {tg, 5'(idx), 5'b0};
      repeat (lat) recs.push_back(mk_rec(1, 1, 0, 0, fetch_addr, '0, '0));
      m_data[idx] = m_get(fetch_addr);
      m_tag[idx] = tg; m_valid[idx] = 1; m_dirty[idx] = 0;
      recs.push_back(mk_rec(1, 0, 0, 0, '0, '0, '0));
    end
    word = m_data[idx][off*32 +: 32];
    recs.push_back(mk_rec(0, 0, 0, rd, '0, word, '0));
    if (wr) begin
      m_data[idx][off*32 +: 32] = wdata;
      m_dirty[idx] = 1;
    end
    n_cyc = recs.size();
    foreach (recs[i]) begin
      @(posedge clk); #1;
      rst = 1'b0; spur = 1'b0;
      cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdata = wdata;
      exp_q.push_back(recs[i]);
    end
  endtask

  // Clean read miss interrupted by reset after k ALLOCATE cycles.
  task automatic rst_mid_alloc(input logic [31:0] addr, input int k);
    logic [31:0] fa;
    fa = {addr[31:5], 5'b0};
    resp_lat = 10;
    for (int i = 0; i <= k + 1; i++) begin
      @(posedge clk); #1;
      spur = 1'b0; rst = (i == k + 1);
      cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = addr; cpu_wdata = '0;
      if (i == 0) exp_q.push_back(mk_rec(1, 0, 0, 0, '0, '0, '0));
      else exp_q.push_back(mk_rec(1, 1, 0, 0, fa, '0, '0));
    end
    @(posedge clk); #1;
    rst = 1'b0; cpu_read = 1'b0;
    exp_q.push_back(mk_rec(0, 0, 0, 0, '0, '0, '0));
    for (int i = 0; i < LINES; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n; bit ms, wb; logic [31:0] wa, fa; logic [255:0] wd;
    rst = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    reset_dut();
    @(negedge clk);
    chk("reset_stall", cpu_stall, 0);
    chk("reset_mem_enable", mem_enable, 0);
    chk("reset_mem_write", mem_write, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_wdata", mem_wdata, 0);
    chk("reset_rdata", cpu_rdata, 0);
    idle(2, 0);

    // Clean miss with 10-cycle memory: 12 stalled cycles, then word 0 of 0x40.
    do_txn(1, 0, 32'h40, '0, 10, n, ms, wb, wa, wd, fa);
    chk("clean_miss_stall_cycles", n - 1, 12);
    chk("first_fetch_addr", fa, 32'h40);
    chk("first_no_wb", wb, 0);
    @(negedge clk);
    chk("rdata_0x40", cpu_rdata, 32'h5A00_4000);

    do_txn(0, 1, 32'h44, 32'hDEADBEEF, 3, n, ms, wb, wa, wd, fa);
    chk("write_hit_cycles", n, 1);
    do_txn(1, 0, 32'h44, '0, 3, n, ms, wb, wa, wd, fa);
    @(negedge clk);
    chk("rdata_0x44", cpu_rdata, 32'hDEADBEEF);

    // Dirty victim: write-back of 0x40 before fetching 0x440.
    do_txn(1, 0, 32'h444, '0, 3, n, ms, wb, wa, wd, fa);
    chk("dirty_wb", wb, 1);
    chk("dirty_wb_addr", wa, 32'h40);
    chk("dirty_wb_word1", wd[63:32], 32'hDEADBEEF);
    chk("dirty_fetch_addr", fa, 32'h440);
    chk("dirty_miss_cycles", n, 9);

    // Clean victim: straight to ALLOCATE.
    do_txn(1, 0, 32'h844, '0, 3, n, ms, wb, wa, wd, fa);
    chk("clean_victim_no_wb", wb, 0);
    chk("clean_victim_fetch", fa, 32'h840);
    chk("clean_victim_cycles", n, 6);

    // Spurious ack while idle must not disturb anything.
    idle(1, 1);
    idle(2, 0);
    do_txn(1, 0, 32'h844, '0, 3, n, ms, wb, wa, wd, fa);
    chk("after_spur_hit", ms, 0);
    @(negedge clk);
    chk("rdata_0x844", cpu_rdata, 32'h5A08_4001);

    // Reset during ALLOCATE.
    rst_mid_alloc(32'h1000, 3);
    @(negedge clk);
    chk("rst_mid_enable", mem_enable, 0);
    do_txn(1, 0, 32'h1000, '0, 2, n, ms, wb, wa, wd, fa);
    chk("rst_remiss", ms, 1);
    do_txn(1, 0, 32'h844, '0, 2, n, ms, wb, wa, wd, fa);
    chk("rst_invalidated", ms, 1);
    chk("rst_invalid_no_wb", wb, 0);

    // Randomized traffic over a few conflicting indices/tags.
    for (int t = 0; t < 300; t++) begin
      int kind;
      bit rd, wr;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      rd = (kind < 4) || (kind >= 8);
      wr = (kind >= 4);
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 5)
        | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      do_txn(rd, wr, a, $urandom, $urandom_range(1, 4), n, ms, wb, wa, wd, fa);
      idle($urandom_range(0, 2), $urandom_range(0, 3) == 0);
    end

    idle(2, 0);
    repeat (3) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
